imem_loader: RTL
================

// Module: imem_loader
// PURPOSE
//  Writer side of the CPU instruction memory. Takes a byte stream (valid/ready) from a host link.
//  Packs each 4 bytes big-endian into one 32-bit MIPS instruction word and writes it to
//  instruction memory through a single write port.
//  Holds the CPU in reset until a complete program image is loaded, then releases it.
// PARAMETERS
//  ADDR_W  12  instruction memory word-address width (4096 words)
//  DATA_W  32  instruction word width; must be 4*8
// PORTS
//  clk         in   1         clock; all logic on posedge
//  rst         in   1         reset, synchronous, active-low (0 = reset)
//  start       in   1         1-cycle request to begin a load; sampled in IDLE and RUN only
//  word_count  in   ADDR_W+1  words to load, 0..2**ADDR_W; latched on accepted start
//  in_valid    in   1         host byte valid
//  in_data     in   8         host byte
//  in_ready    out  1         loader accepts byte; transfer when in_valid & in_ready
//  imem_we     out  1         instruction memory write strobe, 1 cycle per word
//  imem_addr   out  ADDR_W    word address of current write
//  imem_wdata  out  DATA_W    packed instruction word
//  cpu_rst     out  1         active-high reset to CPU; 1 = CPU held
//  busy        out  1         1 in LOAD/WRITE
//  done        out  1         1-cycle pulse on entry to RUN
// BEHAVIOUR
//  Reset (rst=0 at posedge)
//  - state=IDLE. cpu_rst=1; in_ready, imem_we, busy, done=0; imem_addr, imem_wdata=0.
//  - Byte and word counters = 0.
//  FSM
//  - IDLE: start -> latch word_count, addr=0, byte_cnt=0.
//    If word_count==0: go to RUN, done pulse. Else go to LOAD.
//  - LOAD: in_ready=1. Each handshake shifts in the byte: wdata = {wdata[23:0], in_data}.
//    First byte lands in [31:24]. byte_cnt++.
//    Handshake with byte_cnt==3 -> WRITE; byte_cnt wraps to 0.
//  - WRITE: exactly 1 cycle. imem_we=1, in_ready=0; imem_addr/imem_wdata stable.
//    Next edge: addr++, words++. words==count -> RUN with done=1 for one cycle; else -> LOAD.
//  - RUN: cpu_rst=0, in_ready=0.
//    start -> LOAD (or RUN with a new done pulse if word_count==0).
//    cpu_rst returns to 1 the cycle after start.
//  Timing
//  - All outputs registered.
//  - imem_we is high the cycle after the 4th byte handshake.
//  - Minimum 5 cycles per word.
//  - cpu_rst falls in the same cycle done is high.
//  - busy == (state==LOAD || state==WRITE).
//  Boundaries
//  - start while busy: ignored; word_count is not re-latched.
//  - in_valid low mid-word: partial word held indefinitely; no timeout.
//  - word_count==2**ADDR_W: last write at addr 2**ADDR_W-1.
//    The ADDR_W+1-bit word counter compares against count; imem_addr wraps to 0 only after done.
//  - word_count > 2**ADDR_W is impossible by width.
//  - rst=0 mid-load: return to reset state the next edge.
//    Partial word is discarded; already-written memory words are not cleared; cpu_rst=1.
//  - start and rst=0 in the same cycle: reset wins.
// STRUCTURE
//  Shared package cpu_pkg:
//  - IMEM_ADDR_W=12, INSTR_W=32
//  - typedef enum logic [1:0] {LD_IDLE, LD_LOAD, LD_WRITE, LD_RUN} loader_state_t
//  Sub-module byte_packer:
//  - 2-bit byte counter plus 32-bit shift register; clear and shift enable inputs; word_full output.
//  FSM, address counter and output registers live in imem_loader.
// TESTING
//  1. Reset, start, word_count=1; bytes 20,08,00,05 with in_valid held high
//     -> imem_we at addr 0, wdata=0x20080005.
//     Then done pulse; cpu_rst 1->0 on the same cycle.
//  2. word_count=3, bytes with random in_valid gaps -> exactly 3 writes at addr 0,1,2.
//     in_ready=0 during each WRITE cycle; done only after the 3rd write.
//  3. rst=0 after 2 bytes of word 1 (word 0 written), then reload word_count=1 with 0xDEADBEEF
//     -> outputs reset on the next edge; new write at addr 0 = 0xDEADBEEF, no stale bytes.
//  4. start pulsed during LOAD with a different word_count -> ignored; original count honoured.
//  5. word_count=0 from IDLE -> no imem_we; RUN the next cycle with done=1, cpu_rst=0.
//  6. word_count=4096 with an incrementing pattern -> last write addr 0xFFF; done after exactly 4096 writes.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU-side constants and the instruction-memory loader state type.
//   IMEM_ADDR_W  instruction memory word-address width
//   INSTR_W      instruction word width (4 bytes)
//   loader_state_t  states of imem_loader
package cpu_pkg;
    localparam int IMEM_ADDR_W = 12;
    localparam int INSTR_W     = 32;
    typedef enum logic [1:0] {LD_IDLE, LD_LOAD, LD_WRITE, LD_RUN} loader_state_t;
endpackage

// File: rtl/byte_packer.sv
// byte_packer: shifts host bytes into a big-endian instruction word.
//   clk, rst (sync, active-low)
//   clr        drop any partial word and restart at byte 0
//   shift      accept din this cycle
//   din        incoming byte; the first of four ends up in the top byte
//   word       packed word (registered)
//   word_full  the current shift completes the word (fourth byte)
module byte_packer #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         shift,
    input  logic [7:0]   din,
    output logic [W-1:0] word,
    output logic         word_full
);
    logic [1:0] cnt;

    assign word_full = cnt == 2'd3;

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            cnt  <= '0;
            word <= '0;
        end else if (shift) begin
            cnt  <= cnt + 2'd1;
            word <= {word[W-9:0], din};
        end
    end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: loads a byte stream into instruction memory, holding the CPU in reset until done.
//   clk, rst (sync, active-low)
//   start, word_count     begin a load of word_count words (accepted in IDLE/RUN)
//   in_valid, in_data,
//   in_ready              host byte stream handshake
//   imem_we, imem_addr,
//   imem_wdata            instruction memory write port
//   cpu_rst               1 holds the CPU in reset
//   busy                  loading (LOAD or WRITE)
//   done                  one-cycle pulse on entering RUN
module imem_loader
    import cpu_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DATA_W = INSTR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done
);
    loader_state_t state, nxt;
    logic [ADDR_W:0] count, words;
    logic hs, take, full, done_nxt;

    byte_packer #(.W(DATA_W)) u_packer (
        .clk      (clk),
        .rst      (rst),
        .clr      (take),
        .shift    (hs),
        .din      (in_data),
        .word     (imem_wdata),
        .word_full(full)
    );

    // in_ready is a register mirroring state==LOAD, so it is safe to gate the handshake with it
    assign hs = in_valid && in_ready;

    always_comb begin
        nxt  = state;
        take = 1'b0;
        case (state)
            LD_IDLE, LD_RUN: begin
                take = start;
                if (start) nxt = (word_count == '0) ? LD_RUN : LD_LOAD;
            end
            LD_LOAD:  nxt = (hs && full) ? LD_WRITE : LD_LOAD;
            LD_WRITE: nxt = (words + 1'b1 == count) ? LD_RUN : LD_LOAD;
            default:  nxt = LD_IDLE;
        endcase
        // a zero-length restart from RUN stays in RUN but still pulses done
        done_nxt = (nxt == LD_RUN) && (state != LD_RUN || take);
    end

    // outputs are registered from the next state so they line up with the state they describe
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= LD_IDLE;
            in_ready  <= 1'b0;
            imem_we   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cpu_rst   <= 1'b1;
            imem_addr <= '0;
            words     <= '0;
            count     <= '0;
        end else begin
            state    <= nxt;
            in_ready <= nxt == LD_LOAD;
            imem_we  <= nxt == LD_WRITE;
            busy     <= nxt == LD_LOAD || nxt == LD_WRITE;
            done     <= done_nxt;
            cpu_rst  <= nxt != LD_RUN;
            if (take) begin
                count     <= word_count;
                imem_addr <= '0;
                words     <= '0;
            end else if (state == LD_WRITE) begin
                imem_addr <= imem_addr + 1'b1;
                words     <= words + 1'b1;
            end
        end
    end
endmodule
